// File: rtl/hazard_pipe_ctrl.sv
// Destination/write-back control pipeline feeding the bypass network, with load-use
// stall detection, branch flush, memory freeze and a saturating stall-cycle counter.
module hazard_pipe_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             branch_flush,
    input  logic             mem_ready,
    output logic [4:0]       id_ex_rd,
    output logic [4:0]       ex_mem_rd,
    output logic [4:0]       mem_wb_rd,
    output logic             id_ex_wb,
    output logic             ex_mem_wb,
    output logic             mem_wb_wb,
    output logic             id_ex_memread,
    output logic             ex_mem_memread,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {ModeRun, ModeLoadUse, ModeFlush, ModeFreeze} mode_e;

    mode_e            mode;
    logic             load_use;
    logic             stall_inc;
    logic [4:0]       id_ex_rd_q, ex_mem_rd_q, mem_wb_rd_q;
    logic             id_ex_wb_q, ex_mem_wb_q, mem_wb_wb_q;
    logic             id_ex_memread_q, ex_mem_memread_q;
    logic [4:0]       id_ex_rd_d;
    logic             id_ex_wb_d, id_ex_memread_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        load_use = id_ex_memread_q & id_ex_wb_q & (id_ex_rd_q != 5'd0) &
                   ((id_ex_rd_q == if_id_rs) | (if_id_uses_rt & (id_ex_rd_q == if_id_rt)));
        if (!mem_ready) begin
            mode = ModeFreeze;
        end else if (branch_flush) begin
            mode = ModeFlush;
        end else if (load_use) begin
            mode = ModeLoadUse;
        end else begin
            mode = ModeRun;
        end
    end

    always_comb begin
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_bubble    = 1'b0;
        stall_inc       = 1'b0;
        unique case (mode)
            ModeFreeze: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                stall_inc   = 1'b1;
            end
            ModeFlush: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            ModeLoadUse: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                stall_inc    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        id_ex_rd_d      = id_rd;
        // r0 is never a real destination, so it must not look like a producer
        id_ex_wb_d      = id_regwrite & (id_rd != 5'd0);
        id_ex_memread_d = id_memread;
        if (id_ex_bubble) begin
            id_ex_rd_d      = 5'd0;
            id_ex_wb_d      = 1'b0;
            id_ex_memread_d = 1'b0;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_rd_q       <= 5'd0;
            ex_mem_rd_q      <= 5'd0;
            mem_wb_rd_q      <= 5'd0;
            id_ex_wb_q       <= 1'b0;
            ex_mem_wb_q      <= 1'b0;
            mem_wb_wb_q      <= 1'b0;
            id_ex_memread_q  <= 1'b0;
            ex_mem_memread_q <= 1'b0;
            stall_cnt_q      <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (mem_ready) begin
                id_ex_rd_q       <= id_ex_rd_d;
                id_ex_wb_q       <= id_ex_wb_d;
                id_ex_memread_q  <= id_ex_memread_d;
                ex_mem_rd_q      <= id_ex_rd_q;
                ex_mem_wb_q      <= id_ex_wb_q;
                ex_mem_memread_q <= id_ex_memread_q;
                mem_wb_rd_q      <= ex_mem_rd_q;
                mem_wb_wb_q      <= ex_mem_wb_q;
            end
        end
    end

    assign id_ex_rd       = id_ex_rd_q;
    assign ex_mem_rd      = ex_mem_rd_q;
    assign mem_wb_rd      = mem_wb_rd_q;
    assign id_ex_wb       = id_ex_wb_q;
    assign ex_mem_wb      = ex_mem_wb_q;
    assign mem_wb_wb      = mem_wb_wb_q;
    assign id_ex_memread  = id_ex_memread_q;
    assign ex_mem_memread = ex_mem_memread_q;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: directed and random steps checked against a
// stage-list model; a 3-bit counter instance exercises saturation.
module tb_hazard_pipe_ctrl;

    typedef struct packed {
        logic [4:0] rd;
        logic       wb;
        logic       mr;
    } stage_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] if_id_rs = '0, if_id_rt = '0, id_rd = '0;
    logic       if_id_uses_rt = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;
    logic       branch_flush = 1'b0, mem_ready = 1'b1;

    logic [4:0]  id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic        id_ex_wb, ex_mem_wb, mem_wb_wb, id_ex_memread, ex_mem_memread;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [15:0] stall_cnt;

    logic [4:0] s_id_ex_rd, s_ex_mem_rd, s_mem_wb_rd;
    logic       s_id_ex_wb, s_ex_mem_wb, s_mem_wb_wb, s_id_ex_memread, s_ex_mem_memread;
    logic       s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble;
    logic [2:0] s_stall_cnt;

    stage_t m_pipe[3];
    int     m_stalls;
    int     n_pass = 0, n_fail = 0, n_total = 0;

    always #5 clk = ~clk;

    hazard_pipe_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_uses_rt(if_id_uses_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .branch_flush(branch_flush), .mem_ready(mem_ready),
        .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .id_ex_wb(id_ex_wb), .ex_mem_wb(ex_mem_wb), .mem_wb_wb(mem_wb_wb),
        .id_ex_memread(id_ex_memread), .ex_mem_memread(ex_mem_memread),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .stall_cnt(stall_cnt)
    );

    hazard_pipe_ctrl #(.CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_uses_rt(if_id_uses_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .branch_flush(branch_flush), .mem_ready(mem_ready),
        .id_ex_rd(s_id_ex_rd), .ex_mem_rd(s_ex_mem_rd), .mem_wb_rd(s_mem_wb_rd),
        .id_ex_wb(s_id_ex_wb), .ex_mem_wb(s_ex_mem_wb), .mem_wb_wb(s_mem_wb_wb),
        .id_ex_memread(s_id_ex_memread), .ex_mem_memread(s_ex_mem_memread),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
        .id_ex_bubble(s_id_ex_bubble), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_load_use();
        return m_pipe[0].mr && m_pipe[0].wb && (m_pipe[0].rd != 0) &&
               ((m_pipe[0].rd == if_id_rs) || (if_id_uses_rt && (m_pipe[0].rd == if_id_rt)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = '0;
        m_stalls = 0;
    endtask

    // Combinational outputs: {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    function automatic logic [3:0] m_ctrl();
        if (!mem_ready) return 4'b0000;
        if (branch_flush) return 4'b1111;
        if (m_load_use()) return 4'b0001;
        return 4'b1100;
    endfunction

    task automatic check_ctrl(input string tag);
        logic [3:0] e;
        e = m_ctrl();
        chk({tag, ".ctrl"}, {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, {28'd0, e});
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".id_ex"}, {26'd0, id_ex_rd, id_ex_wb, id_ex_memread},
            {26'd0, m_pipe[0].rd, m_pipe[0].wb, m_pipe[0].mr});
        chk({tag, ".ex_mem"}, {26'd0, ex_mem_rd, ex_mem_wb, ex_mem_memread},
            {26'd0, m_pipe[1].rd, m_pipe[1].wb, m_pipe[1].mr});
        chk({tag, ".mem_wb"}, {26'd0, mem_wb_rd, mem_wb_wb}, {26'd0, m_pipe[2].rd, m_pipe[2].wb});
        chk({tag, ".cnt16"}, {16'd0, stall_cnt}, (m_stalls > 65535) ? 65535 : m_stalls);
        chk({tag, ".cnt3"}, {29'd0, s_stall_cnt}, (m_stalls > 7) ? 7 : m_stalls);
    endtask

    // One clock: check control before the edge, advance the model, check registers after.
    task automatic step(input string tag);
        logic   [3:0] c;
        bit           kill;
        stage_t       nxt;
        #1;
        check_ctrl(tag);
        c    = m_ctrl();
        kill = c[0];
        @(posedge clk);
        if (!mem_ready || (!branch_flush && m_load_use())) m_stalls++;
        if (mem_ready) begin
            nxt = kill ? stage_t'(0) : stage_t'{id_rd, id_regwrite && (id_rd != 0), id_memread};
            m_pipe[2] = m_pipe[1];
            m_pipe[2].mr = 1'b0;
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = nxt;
        end
        #1;
        check_regs(tag);
    endtask

    task automatic decode(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic [4:0] rd, input logic rw, input logic mr);
        if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = urt;
        id_rd = rd; id_regwrite = rw; id_memread = mr;
    endtask

    int base;

    initial begin
        model_reset();
        #2;
        check_regs("reset");
        chk("reset.ctrl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, 32'hC);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then RUN: rd=5 propagates one stage per edge
        decode(5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
        step("run1");
        chk("run1.id_ex_rd", {27'd0, id_ex_rd}, 5);
        step("run2");
        chk("run2.ex_mem_rd", {27'd0, ex_mem_rd}, 5);
        step("run3");
        chk("run3.mem_wb", {26'd0, mem_wb_rd, mem_wb_wb}, {26'd0, 5'd5, 1'b1});
        chk("run3.cnt", {16'd0, stall_cnt}, 0);

        // Load-use: exactly one stall cycle
        decode(5'd1, 5'd2, 1'b0, 5'd8, 1'b1, 1'b1);
        step("ld8");
        decode(5'd8, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        #1;
        chk("lu.ctrl", {28'd0, pc_write, if_id_write, id_ex_bubble}, 32'h1);
        step("lu");
        chk("lu.after", {26'd0, id_ex_wb, ex_mem_rd}, {26'd0, 1'b0, 5'd8});
        chk("lu.cnt", {16'd0, stall_cnt}, 1);
        #1;
        chk("lu.released", {31'd0, pc_write}, 1);
        step("lu_next");

        // r0 load does not stall
        decode(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1);
        step("ld0");
        decode(5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        #1;
        chk("r0.pc_write", {31'd0, pc_write}, 1);
        step("r0");

        // rt ignored unless the consumer reads it
        decode(5'd1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b1);
        step("ld9a");
        decode(5'd1, 5'd9, 1'b0, 5'd4, 1'b1, 1'b0);
        #1;
        chk("rt_off.pc_write", {31'd0, pc_write}, 1);
        step("rt_off");
        decode(5'd1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b1);
        step("ld9b");
        decode(5'd1, 5'd9, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        chk("rt_on.pc_write", {31'd0, pc_write}, 0);
        step("rt_on");
        step("rt_on_next");

        // Flush beats load-use; no stall counted
        decode(5'd1, 5'd2, 1'b0, 5'd10, 1'b1, 1'b1);
        step("ld10");
        decode(5'd10, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        branch_flush = 1'b1;
        base = m_stalls;
        #1;
        chk("flush.ctrl", {28'd0, pc_write, if_id_flush, id_ex_bubble}, 32'h7);
        step("flush");
        chk("flush.cnt", {16'd0, stall_cnt}, base);
        branch_flush = 1'b0;

        // Freeze for 4 cycles with a load-use pending, then one bubble
        decode(5'd1, 5'd2, 1'b0, 5'd11, 1'b1, 1'b1);
        step("ld11");
        decode(5'd11, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        base = m_stalls;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("freeze");
        chk("freeze.cnt", {16'd0, stall_cnt}, base + 4);
        mem_ready = 1'b1;
        #1;
        chk("unfreeze.bubble", {31'd0, id_ex_bubble}, 1);
        step("unfreeze");
        chk("unfreeze.cnt", {16'd0, stall_cnt}, base + 5);
        step("unfreeze_next");

        // Randomized traffic with small register numbers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            decode(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            mem_ready    = ($urandom_range(0, 4) != 0);
            branch_flush = ($urandom_range(0, 9) == 0);
            step("rand");
        end
        mem_ready = 1'b1;
        branch_flush = 1'b0;

        // Saturation from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) step("sat");
        chk("sat.cnt3", {29'd0, s_stall_cnt}, 7);
        chk("sat.cnt16", {16'd0, stall_cnt}, 10);
        mem_ready = 1'b1;

        // Async reset pulse between edges, with state in flight
        decode(5'd1, 5'd2, 1'b0, 5'd6, 1'b1, 1'b1);
        step("pre_rst1");
        decode(5'd6, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0);
        step("pre_rst2");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("async_rst");
        chk("async_rst.ctrl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, 32'hC);
        rst_n = 1'b1;
        step("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
